// File: rtl/alu_round_stage_pkg.sv
// Shared constants for the ALU output stage: opcode encodings, flag bit
// positions and the default datapath widths.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    SEL_ADD = 2'b00,
    SEL_SUB = 2'b01,
    SEL_MUL = 2'b10,
    SEL_SHF = 2'b11
  } sel_e;

  // out_flags = {sat, rnd_up, carry, ovf}
  localparam int FLG_OVF   = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_RND   = 2;
  localparam int FLG_SAT   = 3;
  localparam int FLG_W     = 4;

endpackage

// File: rtl/alu_round_stage_if.sv
// Handshake bus between the ALU, the round stage and its consumer.
// slave = the stage itself, master = the driving/consuming environment.
interface alu_round_stage_if #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int PROD_W = alu_pkg::PROD_W
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sel;
  logic [DATA_W-1:0] in_y1;
  logic [PROD_W-1:0] in_y2;
  logic [DATA_W-1:0] in_y3;
  logic              in_cout;
  logic              in_carry_out;
  logic              in_m;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_aux;
  logic [FLG_W-1:0]  out_flags;

  modport slave (
    input  in_valid, in_sel, in_y1, in_y2, in_y3, in_cout, in_carry_out, in_m,
    input  out_ready,
    output in_ready, out_valid, out_data, out_aux, out_flags
  );

  modport master (
    output in_valid, in_sel, in_y1, in_y2, in_y3, in_cout, in_carry_out, in_m,
    output out_ready,
    input  in_ready, out_valid, out_data, out_aux, out_flags
  );

endinterface

// File: rtl/alu_round_stage_round_sat.sv
// Combinational product reduction: drop FRAC_W fraction bits with
// round-half-even, then either clip to all-ones or wrap on overflow.
module round_sat #(
  parameter int DATA_W = 16,
  parameter int PROD_W = 32,
  parameter int FRAC_W = 8,
  parameter int SAT_EN = 1
) (
  input  logic [PROD_W-1:0] prod_i,
  output logic [DATA_W-1:0] data_o,
  output logic              rnd_up_o,
  output logic              sat_o
);

  localparam int QW = PROD_W - FRAC_W;

  logic [QW-1:0] q;
  logic [QW:0]   q2;
  logic          rnd;
  logic          ovf;

  assign q = prod_i[PROD_W-1:FRAC_W];

  // round bit is the msb of the discarded field, sticky is the OR of the rest
  if (FRAC_W == 0) begin : g_trunc
    assign rnd = 1'b0;
  end else if (FRAC_W == 1) begin : g_f1
    assign rnd = prod_i[0] & q[0];
  end else begin : g_fn
    assign rnd = prod_i[FRAC_W-1] & ((|prod_i[FRAC_W-2:0]) | q[0]);
  end

  // one extra bit so the rounding carry out of q is never lost
  assign q2  = {1'b0, q} + {{QW{1'b0}}, rnd};
  assign ovf = |q2[QW:DATA_W];

  assign sat_o    = (SAT_EN != 0) & ovf;
  assign data_o   = sat_o ? {DATA_W{1'b1}} : q2[DATA_W-1:0];
  assign rnd_up_o = rnd;

endmodule

// File: rtl/alu_round_stage.sv
// Two-stage registered output stage after the ALU. S1 selects/rounds the
// ALU result, S2 is the output register; a saturating counter tracks
// clipped products leaving the stage.
module alu_round_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int PROD_W = alu_pkg::PROD_W,
  parameter int FRAC_W = 8,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_round_stage_if.slave bus,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
);

  logic              s1_valid_q, s2_valid_q;
  logic [DATA_W-1:0] s1_data_q, s1_aux_q, s2_data_q, s2_aux_q;
  logic [FLG_W-1:0]  s1_flags_q, s2_flags_q;
  logic [DATA_W-1:0] s1_data_d, s1_aux_d;
  logic [FLG_W-1:0]  s1_flags_d;
  logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

  logic [DATA_W-1:0] rs_data;
  logic              rs_rnd, rs_sat;
  logic              adv1, adv2, accept, sat_xfer;

  // ready depends only on pipeline occupancy and out_ready, never on in_valid
  assign adv2     = ~s2_valid_q | bus.out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign accept   = bus.in_valid & adv1;
  assign sat_xfer = s2_valid_q & bus.out_ready & s2_flags_q[FLG_SAT];

  round_sat #(
    .DATA_W (DATA_W),
    .PROD_W (PROD_W),
    .FRAC_W (FRAC_W),
    .SAT_EN (SAT_EN)
  ) u_round_sat (
    .prod_i   (bus.in_y2),
    .data_o   (rs_data),
    .rnd_up_o (rs_rnd),
    .sat_o    (rs_sat)
  );

  // S1 result select; fields the opcode does not use stay 0
  always_comb begin
    s1_data_d  = '0;
    s1_aux_d   = '0;
    s1_flags_d = '0;
    case (sel_e'(bus.in_sel))
      SEL_ADD: begin
        s1_data_d             = bus.in_y1;
        s1_flags_d[FLG_CARRY] = bus.in_cout;
      end
      SEL_SUB: begin
        s1_data_d             = bus.in_y1;
        s1_flags_d[FLG_CARRY] = bus.in_carry_out;
        s1_flags_d[FLG_OVF]   = bus.in_m;
      end
      SEL_MUL: begin
        s1_data_d           = rs_data;
        s1_flags_d[FLG_RND] = rs_rnd;
        s1_flags_d[FLG_SAT] = rs_sat;
      end
      SEL_SHF: begin
        s1_data_d = bus.in_y1;
        s1_aux_d  = bus.in_y3;
      end
      default: ;
    endcase
  end

  // S1 register: loads on accept, empties when S2 takes its content
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_aux_q   <= '0;
      s1_flags_q <= '0;
    end else if (adv1) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q  <= s1_data_d;
        s1_aux_q   <= s1_aux_d;
        s1_flags_q <= s1_flags_d;
      end
    end
  end

  // S2 output register: holds while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_aux_q   <= '0;
      s2_flags_q <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q  <= s1_data_q;
        s2_aux_q   <= s1_aux_q;
        s2_flags_q <= s1_flags_q;
      end
    end
  end

  // saturating clip counter; clear has priority over a coincident increment
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_clr)
      sat_cnt_d = '0;
    else if (sat_xfer && !(&sat_cnt_q))
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
  end

  // counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_aux   = s2_aux_q;
  assign bus.out_flags = s2_flags_q;
  assign sat_count     = sat_cnt_q;

endmodule
